// File: rtl/prio_arbiter.sv
// prio_arbiter: N-way request arbiter with one registered grant slot.
// Fixed priority by default; define PRIO_ARBITER_RR_EN for round-robin.
module prio_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);

  logic         r_valid;
  logic [W-1:0] r_idx;
  logic         w_acc;
  logic         w_arb;
  logic [W-1:0] w_win;
  logic [N-1:0] w_oh;

  assign w_acc = r_valid & gnt_ready;
  assign w_arb = en & (|req) & (~r_valid | gnt_ready);

`ifdef PRIO_ARBITER_RR_EN
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_ptr_eff;

  // An accept on this edge moves the pointer before the new search
  assign w_ptr_eff = w_acc ? r_idx : r_ptr;

  // Round-robin search: ptr-1 down to 0, then wrap N-1 down to ptr
  always_comb begin
    int k;
    w_win = '0;
    for (int i = N; i >= 1; i--) begin
      k = (int'(w_ptr_eff) + N - i) % N;
      if (req[k]) w_win = W'(k);
    end
  end

  // Pointer tracks the index of the last accepted grant
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (w_acc) r_ptr <= r_idx;
  end
`else
  // Fixed priority: highest set request index wins
  always_comb begin
    w_win = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) w_win = W'(i);
    end
  end
`endif

  // Grant slot: load on arbitration, clear on accept without reload
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else if (w_arb) begin
      r_valid <= 1'b1;
      r_idx   <= w_win;
    end else if (w_acc) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
    end
  end

  // One-hot decode of the held grant, zero when idle
  always_comb begin
    w_oh = '0;
    if (r_valid) w_oh[r_idx] = 1'b1;
  end

  assign gnt_valid  = r_valid;
  assign gnt_idx    = r_idx;
  assign gnt_onehot = w_oh;

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001: Parameter N, default 8: number of request inputs, legal range 2..64.
REQ-002: Parameter W, default $clog2(N): grant index width; derived, never overridden.
REQ-003: clk  input  1  the single clock; every state element updates on its rising edge.
REQ-004: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005: en  input  1  arbitration enable; when low, no new grant is issued.
REQ-006: req  input  N  request vector; bit k set means requester k is asking.
REQ-007: gnt_ready  input  1  the consumer accepts the presented grant.
REQ-008: gnt_valid  output  1  a registered grant is being presented.
REQ-009: gnt_idx  output  W  binary index of the granted requester.
REQ-010: gnt_onehot  output  N  one-hot form of gnt_idx; all zeros when gnt_valid is 0.

Function
REQ-011: The block SHALL sample req on a clock edge ("arbitrate") when en=1, req!=0, and the output slot is free (gnt_valid=0, or gnt_valid=1 and gnt_ready=1).
REQ-012: Latency SHALL be one cycle: an arbitration on edge t gives gnt_valid=1 with the winner on gnt_idx and gnt_onehot from edge t onward.
REQ-013: In fixed-priority mode, the highest set index of req SHALL win; for example, req=8'b0010_0110 gives gnt_idx=5.
REQ-014: While gnt_valid=1 and gnt_ready=0, gnt_idx and gnt_onehot SHALL stay stable regardless of req or en.
REQ-015: If gnt_valid=1 and gnt_ready=1, and no new arbitration happens on that edge, gnt_valid SHALL fall to 0 on that edge.
REQ-016: Accept and re-arbitrate may occur on the same edge; this SHALL give back-to-back grants, one per cycle, with no bubble.
REQ-017: If en=0 while a grant is pending, the pending grant SHALL NOT be cancelled; it remains until accepted.
REQ-018: When gnt_valid=0, gnt_idx SHALL read 0 and gnt_onehot SHALL read all zeros.
REQ-019: gnt_ready while gnt_valid=0 SHALL be ignored.
REQ-020: A request that drops after it was sampled SHALL NOT revoke its issued grant.
REQ-021: gnt_onehot SHALL always equal the decode of gnt_idx whenever gnt_valid=1.

Reset
REQ-022: On a rst edge, the outputs SHALL be gnt_valid=0, gnt_idx=0 and gnt_onehot=0, and the round-robin pointer SHALL be set to 0.
REQ-023: rst SHALL take precedence over every other input; a pending grant is dropped without handshake.
REQ-024: No arbitration SHALL occur on an edge where rst=1.

Configuration
REQ-025: The macro PRIO_ARBITER_RR_EN SHALL select the round-robin feature.
REQ-026: With PRIO_ARBITER_RR_EN defined, the block SHALL hold a W-bit pointer ptr equal to the index of the last accepted grant.
REQ-027: In round-robin mode, the search order SHALL be ptr-1, ptr-2, ... down to 0, then wrap to N-1 ... ptr; the first set request in that order wins.
REQ-028: ptr SHALL update only on an accept edge (gnt_valid&gnt_ready), and it takes the accepted gnt_idx.
REQ-029: An arbitration on an accept edge SHALL use the updated ptr, which is the index being accepted.
REQ-030: In round-robin mode, the first search after reset (ptr=0) SHALL run N-1..0, which is identical to fixed priority.
REQ-031: Without PRIO_ARBITER_RR_EN, the pointer logic SHALL be absent, and the block SHALL be pure fixed priority per REQ-013.

Verification
REQ-032: Reset, then en=1, req=8'h00 for 3 cycles -> gnt_valid stays 0, gnt_idx=0, gnt_onehot=0.
REQ-033: Fixed mode, req=8'h26, gnt_ready=0 for 4 cycles with req changed to 8'h01 -> gnt_idx=5 held, gnt_onehot=8'h20, until ready.
REQ-034: req=8'hFF, gnt_ready=1 held, round-robin build -> gnt_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles. Fixed build -> 7 on every cycle.
REQ-035: Grant pending (idx 3) when en drops to 0 for 2 cycles, then gnt_ready=1 -> idx 3 accepted, then gnt_valid=0 while en=0.
REQ-036: Grant pending, rst asserted one cycle with gnt_ready=1 -> next cycle gnt_valid=0; in the round-robin build ptr=0, so req=8'h81 then grants 7.
REQ-037: Round-robin build, accept idx 2, then req=8'b0000_0110 -> gnt_idx=1; accept, then the same req -> gnt_idx=2.
